// File: rtl/pheap_pkg.sv
// Shared definitions for the heap level-request path: index width, decoder FSM states, popcount.
package pheap_pkg;

    localparam int unsigned POPCNT_MAX_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } lvl_dec_state_t;

    function automatic int lvl_iw(input int levels);
        return $clog2(levels) + 1;
    endfunction

    function automatic logic [5:0] popcount(input logic [POPCNT_MAX_W-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lvl_req_dec_if.sv
// Encoded level-request handshake between heap control (master) and the decoder (slave).
interface lvl_req_dec_if
    import pheap_pkg::*;
#(
    parameter int LEVELS = 4
);
    localparam int IW = lvl_iw(LEVELS);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_lvl;

    modport master (output in_valid, output in_lvl, input in_ready);
    modport slave  (input in_valid, input in_lvl, output in_ready);
endinterface

// File: rtl/lvl_req_dec_pri_enc.sv
// Priority encoder: one-hot of the highest set bit of a, plus idle when a is empty.
module pri_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y,
    output logic         idle
);
    logic found_s;

    // Scan from the top; the first set bit seen masks every lower one.
    always_comb begin
        y       = '0;
        found_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            y[i]    = a[i] & ~found_s;
            found_s = found_s | a[i];
        end
    end

    assign idle = ~|a;
endmodule

// File: rtl/lvl_req_dec.sv
// Level-request decoder: accumulates decoded levels into a pending vector, cleared by ack or a flush drain.
// Optional macro LVL_REQ_DEC_OOR_ERR_EN adds a sticky out-of-range index flag.
module lvl_req_dec
    import pheap_pkg::*;
#(
    parameter int LEVELS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    lvl_req_dec_if.slave                 req,
    input  logic [LEVELS:0]              ack,
    input  logic                         flush,
    output logic [LEVELS:0]              pending,
    output logic [$clog2(LEVELS+2)-1:0]  count,
    output logic                         idle,
    output logic                         flush_done,
    output logic                         oor_err
);
    localparam int IW = lvl_iw(LEVELS);
    localparam int CW = $clog2(LEVELS + 2);
    localparam int W  = LEVELS + 1;

    lvl_dec_state_t state_r, state_nxt_s;
    logic [W-1:0]   pending_r, pending_nxt_s;
    logic           flush_done_r;

    logic           accept_s;
    logic           in_range_s;
    logic [W-1:0]   set_vec_s;
    logic [W-1:0]   post_ack_s;
    logic [W-1:0]   top_bit_s;
    logic [W-1:0]   drain_vec_s;
    logic           enc_idle_s;
    logic           drain_empty_s;

    assign req.in_ready = (state_r == RUN);
    assign accept_s     = req.in_valid & req.in_ready;
    assign in_range_s   = (req.in_lvl <= IW'(LEVELS));

    // Decode by comparison so an out-of-range index never addresses the vector.
    always_comb begin
        set_vec_s = '0;
        for (int i = 0; i < W; i++) begin
            set_vec_s[i] = accept_s & in_range_s & (req.in_lvl == IW'(i));
        end
    end

    assign post_ack_s = pending_r & ~ack;

    pri_enc #(.N(W)) u_pri_enc (
        .a    (post_ack_s),
        .y    (top_bit_s),
        .idle (enc_idle_s)
    );

    assign drain_vec_s   = (state_r == FLUSH) ? top_bit_s : '0;
    // Drain finishes when nothing remains once this cycle's top bit is removed.
    assign drain_empty_s = enc_idle_s | ~|(post_ack_s & ~top_bit_s);
    assign pending_nxt_s = (post_ack_s & ~drain_vec_s) | set_vec_s;

    // Next-state logic for the flush sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (flush) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (drain_empty_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            DONE:    state_nxt_s = RUN;
            default: state_nxt_s = RUN;
        endcase
    end

    // State, pending vector and completion pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            pending_r    <= '0;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pending_r    <= pending_nxt_s;
            flush_done_r <= (state_nxt_s == DONE);
        end
    end

`ifdef LVL_REQ_DEC_OOR_ERR_EN
    logic oor_err_r;

    // Sticky flag for any accepted index beyond the top level.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_err_r <= 1'b0;
        end else begin
            oor_err_r <= oor_err_r | (accept_s & ~in_range_s);
        end
    end

    assign oor_err = oor_err_r;
`else
    assign oor_err = 1'b0;
`endif

    assign pending    = pending_r;
    assign count      = CW'(popcount(POPCNT_MAX_W'(pending_r)));
    assign idle       = (pending_r == '0) && (state_r == RUN);
    assign flush_done = flush_done_r;
endmodule

// File: tb/tb_lvl_req_dec.sv
// Self-checking bench for lvl_req_dec: directed plan checks plus randomized traffic against a behavioural model.
module tb_lvl_req_dec;
    localparam int LEVELS = 4;
    localparam int W      = LEVELS + 1;
    localparam int IW     = 3;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  ack;
    logic          flush;
    logic [W-1:0]  pending;
    logic [CW-1:0] count;
    logic          idle, flush_done, oor_err;

    lvl_req_dec_if #(.LEVELS(LEVELS)) bus ();

    lvl_req_dec #(.LEVELS(LEVELS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.slave),
        .ack        (ack),
        .flush      (flush),
        .pending    (pending),
        .count      (count),
        .idle       (idle),
        .flush_done (flush_done),
        .oor_err    (oor_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a set of pending levels, a "flushing" flag and a done pulse.
    logic [W-1:0] m_pend;
    bit           m_flushing, m_done, m_oor;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [W-1:0] p;
        bit           ready;
        if (rst) begin
            m_pend = '0; m_flushing = 0; m_done = 0; m_oor = 0;
        end else begin
            ready = !m_flushing && !m_done;
            p = m_pend & ~ack;
            if (m_flushing) begin
                for (int i = W - 1; i >= 0; i--) begin
                    if (p[i]) begin
                        p[i] = 1'b0;
                        break;
                    end
                end
                if (p == '0) begin
                    m_flushing = 0;
                    m_done = 1;
                end
            end else if (m_done) begin
                m_done = 0;
            end else begin
                if (bus.in_valid && ready) begin
                    if (bus.in_lvl <= LEVELS) p[bus.in_lvl] = 1'b1;
`ifdef LVL_REQ_DEC_OOR_ERR_EN
                    else m_oor = 1;
`endif
                end
                if (flush) m_flushing = 1;
            end
            m_pend = p;
        end
    end

    always @(negedge clk) begin
        bit ready;
        if (chk_en) begin
            ready = !m_flushing && !m_done;
            cmp("pending",    int'(pending),    int'(m_pend));
            cmp("count",      int'(count),      $countones(m_pend));
            cmp("idle",       int'(idle),       int'(ready && m_pend == '0));
            cmp("in_ready",   int'(bus.in_ready), int'(ready));
            cmp("flush_done", int'(flush_done), int'(m_done));
            cmp("oor_err",    int'(oor_err),    int'(m_oor));
        end
    end

    task automatic cyc(input bit v, input logic [IW-1:0] l, input logic [W-1:0] a, input bit f);
        bus.in_valid = v;
        bus.in_lvl   = l;
        ack          = a;
        flush        = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ack = '0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_lvl = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        cmp("rst_pending", int'(pending), 0);
        cmp("rst_ready",   int'(bus.in_ready), 1);
        cmp("rst_idle",    int'(idle), 1);
        cmp("rst_count",   int'(count), 0);

        cyc(1, 3'd2, 5'b00000, 0);
        cmp("req2", int'(pending), 5'b00100); cmp("req2_cnt", int'(count), 1); cmp("req2_idle", int'(idle), 0);
        cyc(1, 3'd0, 5'b00000, 0);
        cmp("req0", int'(pending), 5'b00101); cmp("req0_cnt", int'(count), 2);
        cyc(1, 3'd4, 5'b00000, 0);
        cmp("req4", int'(pending), 5'b10101); cmp("req4_cnt", int'(count), 3);

        cyc(1, 3'd2, 5'b00100, 0);
        cmp("set_wins", int'(pending), 5'b10101);
        cyc(0, 3'd0, 5'b10001, 0);
        cmp("ack", int'(pending), 5'b00100); cmp("ack_cnt", int'(count), 1);

        cyc(1, 3'd1, 5'b00000, 0);
        cyc(1, 3'd4, 5'b00000, 0);
        cmp("pre_flush", int'(pending), 5'b10110);
        cyc(0, 3'd0, 5'b00000, 1);
        cmp("fl_ready0", int'(bus.in_ready), 0);
        cyc(0, 3'd0, 5'b00000, 0);
        cmp("drain1", int'(pending), 5'b00110); cmp("fl_ready1", int'(bus.in_ready), 0);
        cyc(0, 3'd0, 5'b00000, 0);
        cmp("drain2", int'(pending), 5'b00010); cmp("fl_ready2", int'(bus.in_ready), 0);
        cyc(0, 3'd0, 5'b00000, 0);
        cmp("drain3", int'(pending), 5'b00000); cmp("fl_done", int'(flush_done), 1);
        cmp("fl_ready3", int'(bus.in_ready), 0);
        cyc(0, 3'd0, 5'b00000, 0);
        cmp("post_fl_ready", int'(bus.in_ready), 1); cmp("post_fl_idle", int'(idle), 1);
        cmp("post_fl_done", int'(flush_done), 0);

        cyc(0, 3'd0, 5'b00000, 1);
        cmp("empty_fl_ready", int'(bus.in_ready), 0);
        cyc(1, 3'd3, 5'b00000, 0);
        cmp("empty_fl_done", int'(flush_done), 1); cmp("blocked_req", int'(pending), 0);
        cyc(1, 3'd3, 5'b00000, 0);
        cmp("run_again", int'(bus.in_ready), 1); cmp("still_blocked", int'(pending), 0);
        cyc(1, 3'd3, 5'b00000, 0);
        cmp("req3", int'(pending), 5'b01000);

        cyc(1, 3'd6, 5'b00000, 0);
        cmp("oor_pending", int'(pending), 5'b01000);
        cmp("oor_ready",   int'(bus.in_ready), 1);
`ifdef LVL_REQ_DEC_OOR_ERR_EN
        cmp("oor_flag", int'(oor_err), 1);
`else
        cmp("oor_flag", int'(oor_err), 0);
`endif

        cyc(1, 3'd0, 5'b00000, 0);
        cyc(1, 3'd1, 5'b00000, 0);
        cyc(1, 3'd2, 5'b00000, 0);
        cyc(1, 3'd4, 5'b00000, 0);
        cmp("all_set", int'(pending), 5'b11111);
        cyc(0, 3'd0, 5'b00000, 1);
        cyc(0, 3'd0, 5'b00000, 0);
        cmp("drain_a", int'(pending), 5'b01111);
        rst = 1'b1;
        cyc(0, 3'd0, 5'b00000, 0);
        rst = 1'b0;
        cmp("abort_pending", int'(pending), 0); cmp("abort_ready", int'(bus.in_ready), 1);
        cmp("abort_done", int'(flush_done), 0); cmp("abort_oor", int'(oor_err), 0);

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(bit'($urandom_range(0, 1)), IW'($urandom_range(0, 7)),
                W'($urandom & $urandom & $urandom), ($urandom_range(0, 11) == 0));
        end
        rst = 1'b0;
        cyc(0, 3'd0, 5'b00000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
